// File: rtl/vend_core_n.sv
// N-item vending controller: coin credit accumulation, per-item pricing,
// sensor-confirmed dispense and tick-paced change return on one system clock.
module vend_core_n #(
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned PRICE_W    = 8,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {8'd10, 8'd7, 8'd5, 8'd3},
  parameter int unsigned MAX_CREDIT = 99,
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned DISP_TICKS = 20,
  parameter int unsigned IDLE_TICKS = 300,
  localparam int unsigned IDX_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               coin_valid,
  input  logic [1:0]         coin_val,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic               cancel,
  input  logic               BTN_sensor,
  output logic [N_ITEMS-1:0] dispense,
  output logic               change_pulse,
  output logic               coin_reject,
  output logic [PRICE_W-1:0] credit,
  output logic               busy,
  output logic               err
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMR_MAX = (DISP_TICKS > IDLE_TICKS) ? DISP_TICKS : IDLE_TICKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned SUM_W   = PRICE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t             state, state_d;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick_c;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [PRICE_W-1:0] credit_d;
  logic [N_ITEMS-1:0] dispense_d;
  logic               change_d, reject_d, err_d, busy_d;

  logic [PRICE_W-1:0] coin_units_c;
  logic [SUM_W-1:0]   coin_sum_c;
  logic               coin_seen_c, coin_ok_c;
  logic [PRICE_W-1:0] credit_in_c;
  logic [PRICE_W-1:0] sel_price_c, held_price_c;
  logic               sel_ok_c, activity_c;

  function automatic logic [PRICE_W-1:0] price_of(input logic [IDX_W-1:0] idx);
    price_of = '0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (IDX_W'(i) == idx) price_of = PRICES[i*PRICE_W +: PRICE_W];
    end
  endfunction

  // Free-running tick prescaler, independent of FSM state
  assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        tick_cnt <= '0;
    else if (tick_c) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Coin evaluation and selection qualification
  always_comb begin
    coin_units_c = '0;
    case (coin_val)
      2'b01:   coin_units_c = PRICE_W'(1);
      2'b10:   coin_units_c = PRICE_W'(2);
      2'b11:   coin_units_c = PRICE_W'(5);
      default: coin_units_c = '0;
    endcase
    coin_seen_c  = coin_valid && (coin_val != 2'b00);
    coin_sum_c   = {1'b0, credit} + {1'b0, coin_units_c};
    coin_ok_c    = coin_seen_c && ((state == S_IDLE) || (state == S_CREDIT))
                   && (coin_sum_c <= SUM_W'(MAX_CREDIT));
    credit_in_c  = coin_ok_c ? coin_sum_c[PRICE_W-1:0] : credit;
    sel_price_c  = price_of(sel_idx);
    held_price_c = price_of(sel_q);
    sel_ok_c     = sel_valid && (32'(sel_idx) < N_ITEMS) && (sel_price_c <= credit_in_c);
    activity_c   = coin_seen_c || sel_valid || cancel;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    credit_d   = credit;
    dispense_d = dispense;
    timer_d    = timer;
    sel_d      = sel_q;
    change_d   = 1'b0;
    reject_d   = coin_seen_c && !coin_ok_c;
    err_d      = coin_ok_c ? 1'b0 : err;

    case (state)
      S_IDLE: begin
        if (coin_ok_c) begin
          state_d  = S_CREDIT;
          credit_d = credit_in_c;
          timer_d  = '0;
        end
      end
      S_CREDIT: begin
        credit_d = credit_in_c;
        if (cancel) begin
          state_d = S_CHANGE;
          timer_d = '0;
        end else if (sel_ok_c) begin
          state_d    = S_DISPENSE;
          sel_d      = sel_idx;
          dispense_d = N_ITEMS'(1) << sel_idx;
          timer_d    = '0;
        end else if (activity_c) begin
          timer_d = '0;
        end else if (tick_c) begin
          if (timer == TMR_W'(IDLE_TICKS - 1)) begin
            state_d = S_CHANGE;
            timer_d = '0;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end
      S_DISPENSE: begin
        if (BTN_sensor) begin
          credit_d   = credit - held_price_c;
          dispense_d = '0;
          state_d    = (credit == held_price_c) ? S_IDLE : S_CHANGE;
        end else if (tick_c) begin
          if (timer == TMR_W'(DISP_TICKS - 1)) begin
            err_d      = 1'b1;
            dispense_d = '0;
            state_d    = S_CHANGE;
            timer_d    = '0;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end
      S_CHANGE: begin
        // Last unit leaves on the same edge the FSM returns to IDLE
        if (credit == '0) begin
          state_d = S_IDLE;
        end else if (tick_c) begin
          change_d = 1'b1;
          credit_d = credit - PRICE_W'(1);
          if (credit == PRICE_W'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        credit_d   = '0;
        dispense_d = '0;
      end
    endcase

    busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      timer        <= '0;
      sel_q        <= '0;
      credit       <= '0;
      dispense     <= '0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      sel_q        <= sel_d;
      credit       <= credit_d;
      dispense     <= dispense_d;
      change_pulse <= change_d;
      coin_reject  <= reject_d;
      busy         <= busy_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_vend_core_n.sv
// Self-checking bench for vend_core_n: directed scenarios plus randomized
// purchase sessions scored against a transaction-level credit model.
module tb_vend_core_n;

  localparam int unsigned TDIV   = 4;
  localparam int unsigned DISP_T = 20;
  localparam int unsigned IDLE_T = 300;
  localparam int unsigned MAXC   = 99;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = 2'b00;
  logic       cancel = 1'b0;
  logic       BTN_sensor = 1'b0;
  logic [3:0] dispense;
  logic       change_pulse;
  logic       coin_reject;
  logic [7:0] credit;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  vend_core_n #(.TICK_DIV(TDIV)) dut (
    .CLK(CLK), .RST(RST), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .BTN_sensor(BTN_sensor),
    .dispense(dispense), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .credit(credit), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic int coin_units(input logic [1:0] v);
    case (v)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int price(input int i);
    case (i)
      0:       return 3;
      1:       return 5;
      2:       return 7;
      default: return 10;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin_valid = 1'b1; coin_val = v;
    step();
    coin_valid = 1'b0; coin_val = 2'b00;
  endtask

  task automatic put_sel(input logic [1:0] i);
    sel_valid = 1'b1; sel_idx = i;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic put_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic put_sensor();
    BTN_sensor = 1'b1;
    step();
    BTN_sensor = 1'b0;
  endtask

  // Run until busy drops; measure returned units and their pacing
  task automatic drain(input int budget, output int pulses, output bit spacing_ok, output bit done);
    int last;
    pulses = 0; spacing_ok = 1'b1; done = 1'b0; last = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (change_pulse) begin
        if (last >= 0 && (k - last) != int'(TDIV)) spacing_ok = 1'b0;
        last = k;
        pulses++;
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (dispense !== 4'b0000) begin failures++; $display("FAIL reset_dispense got=%b want=0000", dispense); end
    checks++; if (credit !== 8'd0) begin failures++; $display("FAIL reset_credit got=%0d want=0", credit); end
    checks++; if (change_pulse !== 1'b0) begin failures++; $display("FAIL reset_change got=%b want=0", change_pulse); end
    checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL reset_reject got=%b want=0", coin_reject); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_exact_purchase();
    bit held;
    int p;
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
    checks++; if (credit !== 8'd5) begin failures++; $display("FAIL exact_credit got=%0d want=5", credit); end
    put_sel(2'd1);
    checks++; if (dispense !== 4'b0010) begin failures++; $display("FAIL exact_dispense got=%b want=0010", dispense); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL exact_busy got=%b want=1", busy); end
    held = 1'b1;
    for (int k = 0; k < 3 * int'(TDIV); k++) begin
      step();
      if (dispense !== 4'b0010) held = 1'b0;
    end
    checks++; if (!held) begin failures++; $display("FAIL exact_hold got=%b want=0010", dispense); end
    put_sensor();
    checks++; if (dispense !== 4'b0000) begin failures++; $display("FAIL exact_drop got=%b want=0000", dispense); end
    checks++; if (credit !== 8'd0) begin failures++; $display("FAIL exact_debit got=%0d want=0", credit); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL exact_idle got=%b want=0", busy); end
    p = 0;
    for (int k = 0; k < 5 * int'(TDIV); k++) begin
      step();
      if (change_pulse) p++;
    end
    checks++; if (p != 0) begin failures++; $display("FAIL exact_nochange got=%0d want=0", p); end
  endtask

  task automatic test_purchase_change();
    int p; bit sp, dn;
    put_coin(2'b11); put_coin(2'b11);
    checks++; if (credit !== 8'd10) begin failures++; $display("FAIL chg_credit got=%0d want=10", credit); end
    put_sel(2'd2);
    checks++; if (dispense !== 4'b0100) begin failures++; $display("FAIL chg_dispense got=%b want=0100", dispense); end
    step(); step();
    put_sensor();
    checks++; if (credit !== 8'd3) begin failures++; $display("FAIL chg_debit got=%0d want=3", credit); end
    drain(3 * TDIV + 12, p, sp, dn);
    checks++; if (p != 3) begin failures++; $display("FAIL chg_pulses got=%0d want=3", p); end
    checks++; if (!sp) begin failures++; $display("FAIL chg_spacing got=irregular want=%0d cycles", TDIV); end
    checks++; if (!dn || credit !== 8'd0) begin failures++; $display("FAIL chg_end got=%0d/%b want=0/idle", credit, busy); end
  endtask

  task automatic test_insufficient();
    int p; bit sp, dn;
    put_coin(2'b10); put_coin(2'b01);
    put_sel(2'd3);
    checks++; if (dispense !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL insuf_ignored got=%b/%b want=0000/0", dispense, busy); end
    checks++; if (credit !== 8'd3) begin failures++; $display("FAIL insuf_credit got=%0d want=3", credit); end
    put_cancel();
    drain(3 * TDIV + 12, p, sp, dn);
    checks++; if (p != 3 || !dn) begin failures++; $display("FAIL insuf_refund got=%0d want=3", p); end
    checks++; if (credit !== 8'd0) begin failures++; $display("FAIL insuf_end got=%0d want=0", credit); end
  endtask

  task automatic test_max_credit();
    int p; bit sp, dn;
    for (int k = 0; k < 19; k++) put_coin(2'b11);
    checks++; if (credit !== 8'd95) begin failures++; $display("FAIL max_build got=%0d want=95", credit); end
    put_coin(2'b11);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd95) begin failures++; $display("FAIL max_reject got=%b/%0d want=1/95", coin_reject, credit); end
    step();
    checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL max_reject_pulse got=%b want=0", coin_reject); end
    put_coin(2'b00);
    checks++; if (coin_reject !== 1'b0 || credit !== 8'd95) begin failures++; $display("FAIL max_null_coin got=%b/%0d want=0/95", coin_reject, credit); end
    put_coin(2'b10);
    checks++; if (coin_reject !== 1'b0 || credit !== 8'd97) begin failures++; $display("FAIL max_accept got=%b/%0d want=0/97", coin_reject, credit); end
    put_sel(2'd3);
    put_coin(2'b01);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd97) begin failures++; $display("FAIL max_disp_reject got=%b/%0d want=1/97", coin_reject, credit); end
    put_sensor();
    checks++; if (credit !== 8'd87) begin failures++; $display("FAIL max_debit got=%0d want=87", credit); end
    drain(87 * TDIV + 12, p, sp, dn);
    checks++; if (p != 87 || !dn || credit !== 8'd0) begin failures++; $display("FAIL max_refund got=%0d want=87", p); end
  endtask

  task automatic test_timeout();
    int k, p; bit sp, dn;
    put_coin(2'b11);
    put_sel(2'd0);
    k = 0;
    while (err !== 1'b1 && k < 120) begin
      step();
      k++;
    end
    checks++; if (k < int'((DISP_T - 1) * TDIV + 1) || k > int'(DISP_T * TDIV)) begin failures++; $display("FAIL timeout_latency got=%0d want=%0d..%0d", k, (DISP_T - 1) * TDIV + 1, DISP_T * TDIV); end
    checks++; if (dispense !== 4'b0000 || credit !== 8'd5) begin failures++; $display("FAIL timeout_state got=%b/%0d want=0000/5", dispense, credit); end
    drain(5 * TDIV + 12, p, sp, dn);
    checks++; if (p != 5 || !dn || !sp) begin failures++; $display("FAIL timeout_refund got=%0d want=5", p); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b want=1", err); end
    put_coin(2'b01);
    checks++; if (err !== 1'b0 || credit !== 8'd1) begin failures++; $display("FAIL timeout_clear got=%b/%0d want=0/1", err, credit); end
    put_cancel();
    drain(TDIV + 12, p, sp, dn);
    checks++; if (p != 1 || !dn) begin failures++; $display("FAIL timeout_flush got=%0d want=1", p); end
  endtask

  task automatic test_reset_mid();
    int p; bit sp, dn;
    put_coin(2'b11);
    put_sel(2'd0);
    #2 RST = 1'b0;
    #1;
    checks++; if (dispense !== 4'b0000 || credit !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b/%0d/%b want=0000/0/0", dispense, credit, busy); end
    @(negedge CLK);
    RST = 1'b1;
    drain(4 * TDIV, p, sp, dn);
    checks++; if (p != 0 || credit !== 8'd0) begin failures++; $display("FAIL rstmid_nochange got=%0d/%0d want=0/0", p, credit); end
  endtask

  task automatic test_same_cycle();
    int p; bit sp, dn;
    put_coin(2'b10); put_coin(2'b10);
    cancel = 1'b1; sel_valid = 1'b1; sel_idx = 2'd0; coin_valid = 1'b1; coin_val = 2'b01;
    step();
    cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = 2'b00;
    checks++; if (dispense !== 4'b0000 || credit !== 8'd5 || busy !== 1'b1) begin failures++; $display("FAIL same_cancel got=%b/%0d want=0000/5", dispense, credit); end
    drain(5 * TDIV + 12, p, sp, dn);
    checks++; if (p != 5 || !dn) begin failures++; $display("FAIL same_refund got=%0d want=5", p); end
    // Coin arriving with the selection makes the price reachable
    put_coin(2'b10);
    sel_valid = 1'b1; sel_idx = 2'd0; coin_valid = 1'b1; coin_val = 2'b01;
    step();
    sel_valid = 1'b0; coin_valid = 1'b0; coin_val = 2'b00;
    checks++; if (dispense !== 4'b0001 || credit !== 8'd3) begin failures++; $display("FAIL same_selcoin got=%b/%0d want=0001/3", dispense, credit); end
    put_sensor();
    checks++; if (credit !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL same_vend got=%0d/%b want=0/0", credit, busy); end
  endtask

  task automatic test_idle_refund();
    int k, p; bit sp, dn;
    put_coin(2'b10);
    k = 0;
    while (busy !== 1'b1 && k < 1400) begin
      step();
      k++;
    end
    checks++; if (k < int'((IDLE_T - 1) * TDIV + 1) || k > int'(IDLE_T * TDIV)) begin failures++; $display("FAIL idle_latency got=%0d want=%0d..%0d", k, (IDLE_T - 1) * TDIV + 1, IDLE_T * TDIV); end
    drain(2 * TDIV + 12, p, sp, dn);
    checks++; if (p != 2 || !dn || credit !== 8'd0) begin failures++; $display("FAIL idle_refund got=%0d want=2", p); end
  endtask

  task automatic test_random();
    int m, n, u, i, p;
    bit sp, dn, exp_rej;
    logic [1:0] v;
    for (int it = 0; it < 15; it++) begin
      m = 0;
      n = $urandom_range(1, 25);
      for (int c = 0; c < n; c++) begin
        v = 2'($urandom_range(0, 3));
        u = coin_units(v);
        exp_rej = (u != 0) && (m + u > int'(MAXC));
        if (!exp_rej) m += u;
        put_coin(v);
        checks++; if (credit !== 8'(m) || coin_reject !== exp_rej) begin failures++; $display("FAIL rnd_coin it=%0d got=%0d/%b want=%0d/%b", it, credit, coin_reject, m, exp_rej); end
      end
      i = $urandom_range(0, 3);
      put_sel(2'(i));
      if (m > 0 && price(i) <= m) begin
        checks++; if (dispense !== (4'b0001 << i) || busy !== 1'b1) begin failures++; $display("FAIL rnd_sel it=%0d got=%b want=%b", it, dispense, 4'b0001 << i); end
        repeat ($urandom_range(0, 10)) step();
        put_sensor();
        m -= price(i);
        checks++; if (credit !== 8'(m) || dispense !== 4'b0000) begin failures++; $display("FAIL rnd_debit it=%0d got=%0d want=%0d", it, credit, m); end
      end else begin
        checks++; if (dispense !== 4'b0000 || credit !== 8'(m)) begin failures++; $display("FAIL rnd_ignore it=%0d got=%b/%0d want=0000/%0d", it, dispense, credit, m); end
        put_cancel();
      end
      drain(m * int'(TDIV) + 12, p, sp, dn);
      checks++; if (p != m || !dn || !sp || credit !== 8'd0) begin failures++; $display("FAIL rnd_refund it=%0d got=%0d want=%0d", it, p, m); end
    end
  endtask

  initial begin
    RST = 1'b0;
    repeat (3) step();
    test_reset();
    RST = 1'b1;
    step();
    test_reset();
    test_exact_purchase();
    test_purchase_change();
    test_insufficient();
    test_max_credit();
    test_timeout();
    test_reset_mid();
    test_same_cycle();
    test_idle_refund();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
